// File: rtl/conv2_pkg.sv
// Shared types, widths and the final clamp for the layer-2 conv filter tap.
// Q16.16 operands, 48-bit product terms, guarded adder-tree width.
package conv2_pkg;

  localparam int DATA_W = 32;
  localparam int FRAC_W = 16;
  localparam int TAPS   = 9;
  localparam int ACC_W  = 48;
  // Guard bits so ten full-scale terms cannot wrap before the clamp.
  localparam int SUM_W  = ACC_W + 4;

  typedef logic signed [DATA_W-1:0] q16_t;
  typedef logic signed [ACC_W-1:0]  acc_t;
  typedef logic signed [SUM_W-1:0]  sum_t;

  localparam sum_t SUM_MAX = (sum_t'(1) <<< (DATA_W - 1)) - sum_t'(1);
  localparam sum_t SUM_MIN = -(sum_t'(1) <<< (DATA_W - 1));

  function automatic q16_t sat32(input sum_t acc);
    q16_t r;
    if (acc > SUM_MAX)
      r = 32'h7FFF_FFFF;
    else if (acc < SUM_MIN)
      r = 32'h8000_0000;
    else
      r = q16_t'(acc);
    return r;
  endfunction

endpackage

// File: rtl/conv2_mac_tree.sv
// S2..S4: 9 Q16.16 products plus bias, 3-way partial sums, clamp.
// Ports: clk, rst_n, valid, data[0:8], weight[0:8], bias -> result.
module conv2_mac_tree
  import conv2_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     valid,
  input  logic signed [DATA_W-1:0] data   [0:TAPS-1],
  input  logic signed [DATA_W-1:0] weight [0:TAPS-1],
  input  logic signed [DATA_W-1:0] bias,
  output logic signed [DATA_W-1:0] result
);

  logic signed [2*DATA_W-1:0] prod [0:TAPS-1];
  acc_t term_c [0:TAPS];
  acc_t term   [0:TAPS];
  sum_t psum_c [0:2];
  sum_t psum   [0:2];
  sum_t total;
  logic v2, v3, v4;

  always_comb begin
    for (int k = 0; k < TAPS; k++) begin
      prod[k]   = data[k] * weight[k];
      // Arithmetic shift: truncates toward -inf.
      term_c[k] = acc_t'(prod[k] >>> FRAC_W);
    end
    term_c[TAPS] = {{(ACC_W-DATA_W){bias[DATA_W-1]}}, bias};
  end

  always_comb begin
    psum_c[0] = sum_t'(term[0]) + sum_t'(term[1])
              + sum_t'(term[2]) + sum_t'(term[3]);
    psum_c[1] = sum_t'(term[4]) + sum_t'(term[5])
              + sum_t'(term[6]);
    psum_c[2] = sum_t'(term[7]) + sum_t'(term[8])
              + sum_t'(term[9]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k <= TAPS; k++)
        term[k] <= '0;
      for (int j = 0; j < 3; j++)
        psum[j] <= '0;
      total  <= '0;
      v2     <= 1'b0;
      v3     <= 1'b0;
      v4     <= 1'b0;
      result <= '0;
    end else begin
      for (int k = 0; k <= TAPS; k++)
        term[k] <= term_c[k];
      for (int j = 0; j < 3; j++)
        psum[j] <= psum_c[j];
      total <= psum[0] + psum[1] + psum[2];
      v2    <= valid;
      v3    <= v2;
      v4    <= v3;
      if (v4)
        result <= sat32(total);
    end
  end

endmodule

// File: rtl/conv2_filter.sv
// One output-channel tap of conv2: sum(data*weight) + bias, Q16.16.
// Ports: clk, rst_n, valid_in, data_out[0:8], bias, weight[0:8] -> filter_out.
module conv2_filter
  import conv2_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     valid_in,
  input  logic signed [DATA_W-1:0] data_out [0:TAPS-1],
  input  logic signed [DATA_W-1:0] bias,
  input  logic signed [DATA_W-1:0] weight   [0:TAPS-1],
  output logic signed [DATA_W-1:0] filter_out
);

  q16_t d_r [0:TAPS-1];
  q16_t w_r [0:TAPS-1];
  q16_t b_r;
  logic v1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < TAPS; k++) begin
        d_r[k] <= '0;
        w_r[k] <= '0;
      end
      b_r <= '0;
      v1  <= 1'b0;
    end else begin
      v1 <= valid_in;
      if (valid_in) begin
        for (int k = 0; k < TAPS; k++) begin
          d_r[k] <= data_out[k];
          w_r[k] <= weight[k];
        end
        b_r <= bias;
      end
    end
  end

  conv2_mac_tree u_tree (
    .clk    (clk),
    .rst_n  (rst_n),
    .valid  (v1),
    .data   (d_r),
    .weight (w_r),
    .bias   (b_r),
    .result (filter_out)
  );

endmodule

// File: tb/tb_conv2_filter.sv
// Scoreboard bench for conv2_filter: directed vectors, queued expectations.
// Monitor compares filter_out on the cycle each expectation falls due.
module tb_conv2_filter;
  import conv2_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic valid_in;
  logic signed [31:0] data_out [0:8];
  logic signed [31:0] weight   [0:8];
  logic signed [31:0] bias;
  logic signed [31:0] filter_out;

  conv2_filter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid_in   (valid_in),
    .data_out   (data_out),
    .bias       (bias),
    .weight     (weight),
    .filter_out (filter_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t q[$];
  int cyc = 0;
  int passed = 0;
  int total = 0;
  logic [31:0] last_exp = 32'h0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string nm, logic [31:0] act,
                                logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %08h expected %08h (cycle %0d)",
                  nm, act, exp, cyc);
  endfunction

  function automatic void push(int due, logic [31:0] exp, string nm);
    exp_t e;
    e.due = due;
    e.exp = exp;
    e.name = nm;
    q.push_back(e);
  endfunction

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      exp_t e;
      e = q.pop_front();
      if (e.due < cyc) check({e.name, "_missed"}, 32'h0, 32'h1);
      else check(e.name, filter_out, e.exp);
    end
  end

  task automatic set_all(logic [31:0] d, logic [31:0] w, logic [31:0] b);
    for (int k = 0; k < 9; k++) begin
      data_out[k] = d;
      weight[k]   = w;
    end
    bias = b;
  endtask

  // Called just after a negedge: one-cycle valid pulse, checks latency,
  // result and hold, while scrambling inputs after valid drops.
  task automatic pulse(logic [31:0] exp, string nm);
    int n;
    valid_in = 1'b1;
    n = cyc + 1;
    push(n + 3, last_exp, {nm, "_early"});
    push(n + 4, exp, nm);
    push(n + 5, exp, {nm, "_hold1"});
    push(n + 6, exp, {nm, "_hold2"});
    @(negedge clk);
    valid_in = 1'b0;
    set_all(32'h1234_5678, 32'h0BAD_F00D, 32'h7777_0000);
    last_exp = exp;
    repeat (7) @(negedge clk);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    valid_in = 1'b0;
    set_all(32'h0, 32'h0, 32'h0);
    #3;
    check("reset_async", filter_out, 32'h0);
    @(negedge clk);
    @(negedge clk);
    check("reset_held", filter_out, 32'h0);
    rst_n = 1'b1;
    for (int i = 1; i <= 3; i++) push(cyc + i, 32'h0, "idle_zero");
    repeat (4) @(negedge clk);

    set_all(32'h0, 32'h0, 32'h0000_8000);
    data_out[4] = 32'h0003_0000;
    weight[4]   = 32'h0002_0000;
    pulse(32'h0006_8000, "identity");

    set_all(32'h0001_0000, 32'hFFFF_0000, 32'h0002_0000);
    pulse(32'hFFF9_0000, "neg_sum");

    set_all(32'h7FFF_0000, 32'h7FFF_0000, 32'h0);
    pulse(32'h7FFF_FFFF, "sat_pos");

    set_all(32'h7FFF_0000, 32'h8001_0000, 32'h0);
    pulse(32'h8000_0000, "sat_neg");

    set_all(32'h0, 32'h0001_0000, 32'h0001_0000);
    valid_in = 1'b1;
    n = cyc + 1;
    push(n + 3, last_exp, "b2b_early");
    push(n + 4, 32'h0001_0000, "b2b_0");
    push(n + 5, 32'h0002_0000, "b2b_1");
    push(n + 6, 32'h0003_0000, "b2b_2");
    push(n + 7, 32'h0003_0000, "b2b_hold");
    @(negedge clk);
    bias = 32'h0002_0000;
    @(negedge clk);
    bias = 32'h0003_0000;
    @(negedge clk);
    valid_in = 1'b0;
    bias = 32'h0009_0000;
    last_exp = 32'h0003_0000;
    repeat (7) @(negedge clk);

    set_all(32'h0, 32'h0, 32'h0005_0000);
    valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_mid_pipe", filter_out, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 6; i++) push(cyc + i, 32'h0, "no_late_result");
    repeat (8) @(negedge clk);

    if (q.size() != 0) begin
      check("scoreboard_drained", 32'(q.size()), 32'h0);
      q.delete();
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
